// File: rtl/fft_out_reorder.sv
// fft_out_reorder
// Converts the bit-reversed sample stream of an FFT core into natural index
// order. Two frame-sized banks act as a ping-pong buffer. The write side stores
// each incoming sample at the bit-reversed address of its arrival count. The
// read side streams a full bank out in address order through a registered
// valid/ready output stage.
module fft_out_reorder #(
    parameter int LOG2N = 6,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         in_valid,
    output logic [W-1:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_first,
    output logic         out_last,
    output logic         overflow
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] CNT_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [LOG2N-1:0] CNT_MAX  = {LOG2N{1'b1}};

    // Reverse the bit order of a frame index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // Sample storage. Contents are not reset: a bank is only read after it has been completely rewritten.
    logic [W-1:0] bank0_r [N];
    logic [W-1:0] bank1_r [N];

    // Write-side state
    logic             wbank_r;
    logic [LOG2N-1:0] wcnt_r;
    // Read-side state
    logic             rbank_r;
    logic [LOG2N-1:0] rcnt_r;
    // Per-bank "complete frame waiting to be read" flags
    logic [1:0]       full_r;
    logic             overflow_r;

    // Output stage registers
    logic [W-1:0]     data_out_r;
    logic             out_valid_r;
    logic             out_first_r;
    logic             out_last_r;

    // Combinational control
    logic             wr_accept_s;
    logic             wr_drop_s;
    logic             wr_wrap_s;
    logic [LOG2N-1:0] waddr_s;
    logic             rd_load_s;
    logic             rd_wrap_s;
    logic             out_take_s;
    logic [W-1:0]     rd_data_s;
    logic [1:0]       full_nxt_s;
    logic             wbank_nxt_s;
    logic [LOG2N-1:0] wcnt_nxt_s;
    logic             rbank_nxt_s;
    logic [LOG2N-1:0] rcnt_nxt_s;

    // Handshake decode for both sides of the ping-pong buffer
    always_comb begin
        wr_accept_s = in_valid && !full_r[wbank_r];
        wr_drop_s   = in_valid && full_r[wbank_r];
        wr_wrap_s   = wr_accept_s && (wcnt_r == CNT_MAX);
        waddr_s     = bitrev(wcnt_r);
        out_take_s  = out_valid_r && out_ready;
        rd_load_s   = full_r[rbank_r] && (!out_valid_r || out_ready);
        rd_wrap_s   = rd_load_s && (rcnt_r == CNT_MAX);
    end

    // Read mux: the bank selected by rbank is never the one being written, since a read needs it full and a write needs it not full
    always_comb begin
        if (rbank_r == 1'b1) begin
            rd_data_s = bank1_r[rcnt_r];
        end else begin
            rd_data_s = bank0_r[rcnt_r];
        end
    end

    // Next-state for counters, bank pointers and full flags
    always_comb begin
        full_nxt_s  = full_r;
        wbank_nxt_s = wbank_r;
        wcnt_nxt_s  = wcnt_r;
        rbank_nxt_s = rbank_r;
        rcnt_nxt_s  = rcnt_r;

        if (wr_accept_s) begin
            if (wr_wrap_s) begin
                full_nxt_s[wbank_r] = 1'b1;
                wcnt_nxt_s          = CNT_ZERO;
                wbank_nxt_s         = ~wbank_r;
            end else begin
                wcnt_nxt_s = wcnt_r + CNT_ONE;
            end
        end else begin
            wcnt_nxt_s = wcnt_r;
        end

        // The set above and this clear always target different banks.
        if (rd_load_s) begin
            if (rd_wrap_s) begin
                full_nxt_s[rbank_r] = 1'b0;
                rcnt_nxt_s          = CNT_ZERO;
                rbank_nxt_s         = ~rbank_r;
            end else begin
                rcnt_nxt_s = rcnt_r + CNT_ONE;
            end
        end else begin
            rcnt_nxt_s = rcnt_r;
        end
    end

    // Store accepted samples at their natural-order address
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            if (wbank_r == 1'b1) begin
                bank1_r[waddr_s] <= data_in;
            end else begin
                bank0_r[waddr_s] <= data_in;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank_r    <= 1'b0;
            wcnt_r     <= CNT_ZERO;
            rbank_r    <= 1'b0;
            rcnt_r     <= CNT_ZERO;
            full_r     <= 2'b00;
            overflow_r <= 1'b0;
        end else begin
            wbank_r    <= wbank_nxt_s;
            wcnt_r     <= wcnt_nxt_s;
            rbank_r    <= rbank_nxt_s;
            rcnt_r     <= rcnt_nxt_s;
            full_r     <= full_nxt_s;
            overflow_r <= overflow_r | wr_drop_s;
        end
    end

    // Output stage: load a new sample, retire a taken one, or hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r  <= {W{1'b0}};
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (rd_load_s) begin
            data_out_r  <= rd_data_s;
            out_valid_r <= 1'b1;
            out_first_r <= (rcnt_r == CNT_ZERO);
            out_last_r  <= (rcnt_r == CNT_MAX);
        end else if (out_take_s) begin
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            data_out_r  <= data_out_r;
            out_valid_r <= out_valid_r;
            out_first_r <= out_first_r;
            out_last_r  <= out_last_r;
        end
    end

    assign data_out  = data_out_r;
    assign out_valid = out_valid_r;
    assign out_first = out_first_r;
    assign out_last  = out_last_r;
    assign overflow  = overflow_r;

endmodule
